// File: rtl/fsb_wb_master.sv
// fsb_wb_master: turns single CPU load/store requests into 8-bit Wishbone
// classic cycles. Per-transaction mode select: ACK-terminated with timeout,
// or fixed wait-count with ACK ignored. All outputs are registered.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a request; latch request, mode and wait count
// ST_SYNC  | CYC/STB high, wait for ACK or timeout
// ST_ASYNC | CYC/STB high for W+1 cycles, ACK ignored, data on last cycle
// ST_DONE  | one-cycle rsp_valid pulse, bus idle, not ready
module fsb_wb_master #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clki,
  input  logic          sys_rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_adr,
  input  logic [7:0]    req_dat,
  output logic          rsp_valid,
  output logic [7:0]    rsp_dat,
  output logic          rsp_err,
  input  logic          SYNC_MODE,
  input  logic [6:0]    ASYNC_WAITCYCLE,
  output logic [AW-1:0] WB_ADRo,
  output logic [7:0]    WB_DATo,
  input  logic [7:0]    WB_DATi,
  output logic          WB_WEo,
  output logic          WB_CYCo,
  output logic          WB_STBo,
  input  logic          WB_ACKi
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_ASYNC = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Timeout is a down-counter loaded with TIMEOUT-1; reaching zero without
  // ACK means STB has been high for exactly TIMEOUT cycles.
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

  state_t        state_q;
  logic [7:0]    cnt_q;
  logic          ready_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_dat_q;
  logic          rsp_err_q;
  logic          cyc_q;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [7:0]    dato_q;

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign WB_ADRo   = adr_q;
  assign WB_DATo   = dato_q;
  assign WB_WEo    = we_q;
  // CYC and STB share one register so they can never diverge.
  assign WB_CYCo   = cyc_q;
  assign WB_STBo   = cyc_q;

  // Sequencer: request latch, bus cycle timing and response generation.
  always_ff @(posedge clki or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 8'h00;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dato_q      <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (req_valid && ready_q) begin
            ready_q <= 1'b0;
            cyc_q   <= 1'b1;
            we_q    <= req_we;
            adr_q   <= req_adr;
            dato_q  <= req_we ? req_dat : 8'h00;
            if (SYNC_MODE) begin
              state_q <= ST_SYNC;
              cnt_q   <= TO_LOAD;
            end else begin
              state_q <= ST_ASYNC;
              cnt_q   <= {1'b0, ASYNC_WAITCYCLE};
            end
          end
        end
        ST_SYNC: begin
          // ACK is checked first so it wins over a simultaneous timeout.
          if (WB_ACKi) begin
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= we_q ? 8'h00 : WB_DATi;
            state_q     <= ST_DONE;
          end else if (cnt_q == 8'd0) begin
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_dat_q   <= we_q ? 8'h00 : 8'hFF;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_ASYNC: begin
          if (cnt_q == 8'd0) begin
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= we_q ? 8'h00 : WB_DATi;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          cyc_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsb_wb_master.sv
// Testbench for fsb_wb_master: directed and randomized transactions checked
// against a transaction-level model of strobe length, latency and response.
module tb_fsb_wb_master;
  localparam int AW = 16;
  localparam int TO = 255;

  logic          clki = 1'b0;
  logic          sys_rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_adr = '0;
  logic [7:0]    req_dat = 8'h00;
  logic          rsp_valid;
  logic [7:0]    rsp_dat;
  logic          rsp_err;
  logic          SYNC_MODE = 1'b0;
  logic [6:0]    ASYNC_WAITCYCLE = 7'd0;
  logic [AW-1:0] WB_ADRo;
  logic [7:0]    WB_DATo;
  logic [7:0]    WB_DATi = 8'h00;
  logic          WB_WEo;
  logic          WB_CYCo;
  logic          WB_STBo;
  logic          WB_ACKi = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clki = ~clki;

  fsb_wb_master #(.AW(AW), .TIMEOUT(TO)) dut (
    .clki(clki), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .SYNC_MODE(SYNC_MODE), .ASYNC_WAITCYCLE(ASYNC_WAITCYCLE),
    .WB_ADRo(WB_ADRo), .WB_DATo(WB_DATo), .WB_DATi(WB_DATi),
    .WB_WEo(WB_WEo), .WB_CYCo(WB_CYCo), .WB_STBo(WB_STBo), .WB_ACKi(WB_ACKi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level expectation: how long STB stays up and what comes back.
  task automatic model(input bit sync, input int w, input int ack_k, input bit we,
                       input logic [7:0] rdat, output int stb_len,
                       output logic [7:0] dat, output bit err);
    logic [7:0] rd;
    if (!sync) begin
      stb_len = w + 1; err = 1'b0; rd = rdat;
    end else if (ack_k >= 0 && ack_k < TO) begin
      stb_len = ack_k + 1; err = 1'b0; rd = rdat;
    end else begin
      stb_len = TO; err = 1'b1; rd = 8'hFF;
    end
    dat = we ? 8'h00 : rd;
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clki);
      guard++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
  endtask

  // ack_k: STB cycle index (0-based) in which the slave acks; -1 = never.
  // tied: ACK held high throughout. churn: scramble config/request inputs.
  task automatic txn(input bit sync, input int w, input int ack_k, input bit tied,
                     input bit we, input logic [15:0] adr, input logic [7:0] wdat,
                     input logic [7:0] rdat, input bit churn);
    int exp_len, len, rsp_cyc, n_rsp, stable_bad;
    logic [7:0] exp_dat, got_dat;
    bit exp_err;
    logic got_err, ready_at_rsp, ready_after;
    model(sync, w, tied ? 0 : ack_k, we, rdat, exp_len, exp_dat, exp_err);
    len = 0; rsp_cyc = -1; n_rsp = 0; stable_bad = 0;
    got_dat = 8'hxx; got_err = 1'bx; ready_at_rsp = 1'bx; ready_after = 1'bx;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = wdat;
    SYNC_MODE = sync; ASYNC_WAITCYCLE = w[6:0];
    WB_ACKi = tied; WB_DATi = tied ? rdat : ~rdat;
    @(negedge clki);
    req_valid = 1'b0;
    req_we = ~we; req_adr = ~adr; req_dat = ~wdat;
    for (int c = 1; c <= TO + 10; c++) begin
      if (WB_STBo === 1'b1) begin
        len++;
        if (WB_CYCo !== 1'b1 || WB_ADRo !== adr || WB_WEo !== we ||
            WB_DATo !== (we ? wdat : 8'h00))
          stable_bad++;
      end else if (WB_CYCo !== 1'b0) begin
        stable_bad++;
      end
      if (rsp_valid === 1'b1) begin
        n_rsp++;
        if (rsp_cyc < 0) begin
          rsp_cyc = c; got_dat = rsp_dat; got_err = rsp_err; ready_at_rsp = req_ready;
        end
      end
      if (rsp_cyc > 0 && c == rsp_cyc + 1) begin
        ready_after = req_ready;
        break;
      end
      if (tied) begin
        WB_ACKi = 1'b1; WB_DATi = rdat;
      end else if (sync) begin
        WB_ACKi = (WB_STBo === 1'b1) && (len == ack_k + 1);
        WB_DATi = WB_ACKi ? rdat : ~rdat;
      end else begin
        WB_ACKi = 1'($urandom);
        WB_DATi = (c == exp_len) ? rdat : ~rdat;
      end
      if (churn) begin
        SYNC_MODE = 1'($urandom); ASYNC_WAITCYCLE = 7'($urandom);
      end
      @(negedge clki);
    end
    WB_ACKi = 1'b0;
    check("stb_len", len, exp_len);
    check("rsp_cycle", rsp_cyc, exp_len + 1);
    check("rsp_count", n_rsp, 1);
    check("rsp_dat", {24'd0, got_dat}, {24'd0, exp_dat});
    check("rsp_err", {31'd0, got_err}, {31'd0, exp_err});
    check("bus_stable", stable_bad, 0);
    check("ready_in_done", {31'd0, ready_at_rsp}, 32'd0);
    check("ready_after_done", {31'd0, ready_after}, 32'd1);
  endtask

  task automatic reset_abort();
    int n_rsp;
    n_rsp = 0;
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_adr = 16'h0ABC; req_dat = 8'h00;
    SYNC_MODE = 1'b0; ASYNC_WAITCYCLE = 7'd10;
    @(negedge clki);
    req_valid = 1'b0;
    repeat (2) @(negedge clki);
    check("abort_stb_before", {31'd0, WB_STBo}, 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    check("abort_stb_drop", {31'd0, WB_STBo}, 32'd0);
    check("abort_cyc_drop", {31'd0, WB_CYCo}, 32'd0);
    repeat (3) begin
      @(negedge clki);
      if (rsp_valid !== 1'b0) n_rsp++;
    end
    sys_rst = 1'b0;
    #1;
    check("abort_ready_in_rst", {31'd0, req_ready}, 32'd0);
    @(negedge clki);
    if (rsp_valid !== 1'b0) n_rsp++;
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);
    repeat (12) begin
      @(negedge clki);
      if (rsp_valid !== 1'b0 || WB_STBo !== 1'b0) n_rsp++;
    end
    check("abort_no_rsp", n_rsp, 0);
  endtask

  initial begin
    bit s, we, ch;
    int w, k;
    repeat (3) @(negedge clki);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", {24'd0, rsp_dat}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_cyc", {31'd0, WB_CYCo}, 32'd0);
    check("rst_stb", {31'd0, WB_STBo}, 32'd0);
    check("rst_we", {31'd0, WB_WEo}, 32'd0);
    check("rst_adr", {16'd0, WB_ADRo}, 32'd0);
    check("rst_dato", {24'd0, WB_DATo}, 32'd0);
    sys_rst = 1'b0;
    #1 check("ready_at_release", {31'd0, req_ready}, 32'd0);
    @(negedge clki);
    check("ready_first_edge", {31'd0, req_ready}, 32'd1);

    txn(1'b1, 0,   0, 1'b1, 1'b0, 16'h0004, 8'h00, 8'h5A, 1'b0);
    txn(1'b1, 0,   3, 1'b0, 1'b1, 16'h0009, 8'hC3, 8'h96, 1'b0);
    txn(1'b1, 0,  -1, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h77, 1'b0);
    txn(1'b1, 0, 254, 1'b0, 1'b0, 16'h4321, 8'h00, 8'h81, 1'b0);
    txn(1'b1, 0,  -1, 1'b0, 1'b1, 16'h0F0F, 8'hA5, 8'h11, 1'b0);
    txn(1'b0, 5,   0, 1'b0, 1'b0, 16'h0020, 8'h00, 8'h3C, 1'b0);
    txn(1'b0, 0,   0, 1'b0, 1'b0, 16'h0021, 8'h00, 8'hE7, 1'b0);
    txn(1'b0, 10,  0, 1'b0, 1'b0, 16'h0022, 8'h00, 8'h42, 1'b1);
    txn(1'b0, 127, 0, 1'b0, 1'b1, 16'hFFFF, 8'h5C, 8'h24, 1'b0);
    reset_abort();

    for (int i = 0; i < 25; i++) begin
      s  = 1'($urandom);
      we = 1'($urandom);
      ch = 1'($urandom);
      w  = $urandom_range(0, 20);
      k  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 8);
      txn(s, w, k, 1'b0, we, 16'($urandom), 8'($urandom), 8'($urandom), ch);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
